// File: rtl/fadd_norm.sv
// fadd_norm: normalise, round-to-nearest-even and pack the raw adder result.
// Three registered stages share one advance enable, so a stall freezes the whole pipe.
module fadd_norm #(
  parameter int N       = 32,
  parameter int EXP_LEN = 8,
  parameter int MAN_LEN = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_LEN-1:0] in_exp,
  input  logic [MAN_LEN+4:0] in_man,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out,
  output logic               out_ovf,
  output logic               out_unf,
  output logic               out_inx
);
  localparam int MW  = MAN_LEN + 5;
  localparam int EW  = EXP_LEN + 2;
  localparam int LZW = $clog2(MW);

  typedef logic signed [EW-1:0] sexp_t;
  localparam sexp_t EMAX = sexp_t'((1 << EXP_LEN) - 1);

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic [LZW-1:0] lzc;
  always_comb begin
    lzc = LZW'(MAN_LEN + 4);
    for (int i = 0; i <= MAN_LEN + 3; i++)
      if (in_man[i]) lzc = LZW'(MAN_LEN + 3 - i);
  end

  logic               v1, sign1, spc1, zro1, cry1;
  logic [EXP_LEN-1:0] exp1;
  logic [MW-1:0]      man1;
  logic [LZW-1:0]     lzc1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      spc1  <= 1'b0;
      zro1  <= 1'b0;
      cry1  <= 1'b0;
      exp1  <= '0;
      man1  <= '0;
      lzc1  <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        sign1 <= in_sign;
        exp1  <= in_exp;
        man1  <= in_man;
        lzc1  <= lzc;
        spc1  <= &in_exp;
        zro1  <= ~|in_man;
        cry1  <= in_man[MW-1];
      end
    end
  end

  sexp_t e1, lz1;
  assign e1  = sexp_t'(exp1);
  assign lz1 = sexp_t'(lzc1);

  // byp_n marks beats whose packed word is final before rounding
  logic               byp_n, unf_n, inx_n;
  logic [N-1:0]       word_n;
  sexp_t              exp_n;
  logic [MW-1:0]      man_n;

  always_comb begin
    byp_n  = 1'b1;
    unf_n  = 1'b0;
    inx_n  = 1'b0;
    word_n = '0;
    exp_n  = e1;
    man_n  = man1;
    if (spc1) begin
      word_n = {sign1, {EXP_LEN{1'b1}}, man1[MAN_LEN+2:3]};
    end else if (zro1) begin
      word_n = {sign1, {(N-1){1'b0}}};
    end else if (cry1) begin
      byp_n = 1'b0;
      exp_n = e1 + sexp_t'(1);
      man_n = {1'b0, man1[MW-1:2], man1[1] | man1[0]};
    end else if (lz1 < e1) begin
      byp_n = 1'b0;
      exp_n = e1 - lz1;
      man_n = man1 << lzc1;
    end else begin
      word_n = {sign1, {(N-1){1'b0}}};
      unf_n  = 1'b1;
      inx_n  = 1'b1;
    end
  end

  logic                v2, sign2, byp2, unf2, inx2;
  logic [N-1:0]        word2;
  sexp_t               exp2;
  logic [MAN_LEN+2:0]  man2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      byp2  <= 1'b0;
      unf2  <= 1'b0;
      inx2  <= 1'b0;
      word2 <= '0;
      exp2  <= '0;
      man2  <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        sign2 <= sign1;
        byp2  <= byp_n;
        unf2  <= unf_n;
        inx2  <= inx_n;
        word2 <= word_n;
        exp2  <= exp_n;
        man2  <= man_n[MAN_LEN+2:0];
      end
    end
  end

  logic               g, r, s, lsb, inc;
  logic [MAN_LEN:0]   rnd;
  sexp_t              exp3;

  assign g    = man2[2];
  assign r    = man2[1];
  assign s    = man2[0];
  assign lsb  = man2[3];
  assign inc  = g & (r | s | lsb);
  assign rnd  = {1'b0, man2[MAN_LEN+2:3]} + (MAN_LEN+1)'(inc);
  assign exp3 = exp2 + sexp_t'(rnd[MAN_LEN]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_inx   <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      if (v2) begin
        if (byp2) begin
          out     <= word2;
          out_ovf <= 1'b0;
          out_unf <= unf2;
          out_inx <= inx2;
        end else if (exp3 >= EMAX) begin
          out     <= {sign2, {EXP_LEN{1'b1}}, {MAN_LEN{1'b0}}};
          out_ovf <= 1'b1;
          out_unf <= 1'b0;
          out_inx <= 1'b1;
        end else begin
          out     <= {sign2, exp3[EXP_LEN-1:0], rnd[MAN_LEN-1:0]};
          out_ovf <= 1'b0;
          out_unf <= 1'b0;
          out_inx <= g | r | s;
        end
      end
    end
  end

endmodule
